onehot_pin_decoder: RTL and testbench

// - Receive end of the 4-pin one-hot position link: samples LED/PIN_1..PIN_3-style pins from another board.
// - Synchronises, debounces and decodes the one-hot vector into a 2-bit position number.
// - Reports each accepted position, all-low idle and multi-hot errors to downstream logic.

---
 rtl/onehot_pin_decoder_if.sv | 12 +
 rtl/onehot_pin_decoder.sv | 169 ++++++++++++++++
 tb/tb_onehot_pin_decoder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/onehot_pin_decoder_if.sv
// Pin vector and decoded position/status between the one-hot link receiver and its consumer.
interface onehot_pin_decoder_if;
   logic [3:0] PIN_IN;
   logic [1:0] NUM;
   logic       NUM_VALID;
   logic       IDLE;
   logic       ERR;
   logic       SEQ_ERR;

   modport master (output PIN_IN, input NUM, NUM_VALID, IDLE, ERR, SEQ_ERR);
   modport slave  (input PIN_IN, output NUM, NUM_VALID, IDLE, ERR, SEQ_ERR);
endinterface

// File: rtl/onehot_pin_decoder.sv
// Receive end of the 4-pin one-hot position link: synchronise, debounce, decode to a 2-bit position.
// Define SEQ_CHECK_EN to flag one-hot positions that do not follow the previous one (mod 4).
module onehot_pin_decoder #(
   parameter int STABLE_CYCLES = 16,
   parameter int SYNC_STAGES   = 2,
   parameter int CNT_W         = 16
) (
   input logic                 CLK,
   input logic                 RST,
   onehot_pin_decoder_if.slave pins
);
   // IDLE and ERR are the state bits themselves, so they come straight from flops.
   typedef enum logic [1:0] {
      S_LOCK = 2'b00,
      S_IDLE = 2'b01,
      S_ERR  = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

   function automatic logic [1:0] onehot_index(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   logic [3:0]       sync_r [SYNC_STAGES];
   logic [3:0]       samp_s;
   logic [3:0]       prev_r;
   logic [CNT_W-1:0] cnt_r;
   logic [3:0]       acc_r;
   logic             stable_s;
   logic             accept_s;
   state_t           state_r;
   state_t           next_state_s;
   logic [1:0]       idx_s;
   logic [1:0]       num_r;
   logic             num_valid_r;

   assign samp_s   = sync_r[SYNC_STAGES-1];
   assign stable_s = (samp_s == prev_r) && (cnt_r == CNT_MAX);
   assign accept_s = stable_s && (samp_s != acc_r);

   // Input synchroniser chain.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= 4'b0000;
         end
      end else begin
         sync_r[0] <= pins.PIN_IN;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   // Debounce: count consecutive identical samples, saturating so it never wraps.
   always_ff @(posedge CLK) begin
      if (RST) begin
         prev_r <= 4'b0000;
         cnt_r  <= '0;
      end else begin
         prev_r <= samp_s;
         if (samp_s != prev_r) begin
            cnt_r <= '0;
         end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Classify the synchronised vector into the state it would select.
   always_comb begin
      next_state_s = state_r;
      idx_s        = onehot_index(samp_s);
      if (samp_s == 4'b0000) begin
         next_state_s = S_IDLE;
      end else if (is_onehot(samp_s)) begin
         next_state_s = S_LOCK;
      end else begin
         next_state_s = S_ERR;
      end
   end

   // Position FSM; only an accepted vector moves it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= S_IDLE;
         acc_r       <= 4'b0000;
         num_r       <= 2'd0;
         num_valid_r <= 1'b0;
      end else if (accept_s) begin
         acc_r   <= samp_s;
         state_r <= next_state_s;
         case (next_state_s)
            S_LOCK: begin
               num_r       <= idx_s;
               num_valid_r <= 1'b1;
            end
            S_IDLE, S_ERR: begin
               num_r       <= num_r;
               num_valid_r <= 1'b0;
            end
            default: begin
               num_r       <= num_r;
               num_valid_r <= 1'b0;
            end
         endcase
      end else begin
         num_valid_r <= 1'b0;
      end
   end

   assign pins.NUM       = num_r;
   assign pins.NUM_VALID = num_valid_r;
   assign pins.IDLE      = state_r[0];
   assign pins.ERR       = state_r[1];

`ifdef SEQ_CHECK_EN
   logic [1:0] last_num_r;
   logic       seq_v_r;
   logic       seq_err_r;

   // Sequence tracker; a multi-hot accept leaves the history untouched.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_num_r <= 2'd0;
         seq_v_r    <= 1'b0;
         seq_err_r  <= 1'b0;
      end else if (accept_s) begin
         case (next_state_s)
            S_IDLE: begin
               last_num_r <= 2'd0;
               seq_v_r    <= 1'b0;
               seq_err_r  <= 1'b0;
            end
            S_LOCK: begin
               seq_err_r  <= seq_v_r && (idx_s != (last_num_r + 2'd1));
               last_num_r <= idx_s;
               seq_v_r    <= 1'b1;
            end
            default: begin
               last_num_r <= last_num_r;
               seq_v_r    <= seq_v_r;
               seq_err_r  <= 1'b0;
            end
         endcase
      end else begin
         seq_err_r <= 1'b0;
      end
   end

   assign pins.SEQ_ERR = seq_err_r;
`else
   assign pins.SEQ_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_onehot_pin_decoder.sv
// Bench for onehot_pin_decoder: directed link scenarios plus random pin activity against a window model.
module tb_onehot_pin_decoder;
   localparam int STABLE = 16;
   localparam int SYNC   = 2;
   localparam int LAT    = SYNC + STABLE + 1;
`ifdef SEQ_CHECK_EN
   localparam bit SEQ_ON = 1'b1;
`else
   localparam bit SEQ_ON = 1'b0;
`endif

   logic CLK;
   logic RST;
   onehot_pin_decoder_if bus();

   onehot_pin_decoder #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC), .CNT_W(16)) dut (
      .CLK (CLK),
      .RST (RST),
      .pins(bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   // Model: a vector is taken once it has been the sampled input for STABLE+1 consecutive
   // samples, counted SYNC samples back, and differs from the last one taken.
   logic [3:0] hist[$];
   logic [3:0] m_acc;
   logic [1:0] m_num, m_last;
   logic       m_nv, m_idle, m_err, m_seq, m_sv;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
      end
   endtask

   task automatic model_edge(input logic [3:0] pv, input logic rv);
      logic [3:0] w;
      bit         same;
      int         top;
      int         ones;
      logic [1:0] idx;
      m_nv  = 1'b0;
      m_seq = 1'b0;
      if (rv) begin
         hist.delete();
         for (int k = 0; k <= SYNC; k++) hist.push_back(4'h0);
         m_acc = 4'h0; m_num = 2'd0; m_idle = 1'b1; m_err = 1'b0;
         m_last = 2'd0; m_sv = 1'b0;
      end else begin
         hist.push_back(pv);
         top = hist.size() - 1 - SYNC;
         if (top - STABLE >= 0) begin
            w    = hist[top];
            same = 1'b1;
            for (int k = top - STABLE; k < top; k++) if (hist[k] !== w) same = 1'b0;
            if (same && (w !== m_acc)) begin
               m_acc = w;
               ones  = $countones(w);
               if (ones == 0) begin
                  m_idle = 1'b1; m_err = 1'b0; m_sv = 1'b0; m_last = 2'd0;
               end else if (ones == 1) begin
                  idx = 2'd0;
                  for (int b = 0; b < 4; b++) if (w[b]) idx = 2'(b);
                  m_seq  = SEQ_ON && m_sv && (int'(idx) != ((int'(m_last) + 1) % 4));
                  m_num  = idx; m_nv = 1'b1; m_idle = 1'b0; m_err = 1'b0;
                  m_last = idx; m_sv = 1'b1;
               end else begin
                  m_err = 1'b1; m_idle = 1'b0;
               end
            end
         end
         if (hist.size() > 64) void'(hist.pop_front());
      end
   endtask

   task automatic step(input logic [3:0] pv, input logic rv);
      bus.PIN_IN = pv;
      RST        = rv;
      @(posedge CLK);
      model_edge(pv, rv);
      @(negedge CLK);
      chk("num",       32'(bus.NUM),       32'(m_num));
      chk("num_valid", 32'(bus.NUM_VALID), 32'(m_nv));
      chk("idle",      32'(bus.IDLE),      32'(m_idle));
      chk("err",       32'(bus.ERR),       32'(m_err));
      chk("seq_err",   32'(bus.SEQ_ERR),   32'(m_seq));
   endtask

   // Hold a vector n cycles; report the cycle index of the first NUM_VALID pulse (-1 if none).
   task automatic hold(input logic [3:0] v, input int n, output int first, output int pnum,
                       output int sq);
      first = -1; pnum = -1; sq = -1;
      for (int i = 1; i <= n; i++) begin
         step(v, 1'b0);
         if ((bus.NUM_VALID === 1'b1) && (first < 0)) begin
            first = i;
            pnum  = int'(bus.NUM);
            sq    = int'(bus.SEQ_ERR);
         end
      end
   endtask

   initial begin
      int f, p, s;
      logic [3:0] vals [5];
      int         idxs [5];
      logic [3:0] v;
      int         n;
      vals = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      idxs = '{0, 1, 2, 3, 0};
      bus.PIN_IN = 4'b0000;
      RST        = 1'b1;

      for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
      chk("rst_num",  32'(bus.NUM),  32'd0);
      chk("rst_idle", 32'(bus.IDLE), 32'd1);
      chk("rst_err",  32'(bus.ERR),  32'd0);
      hold(4'b0000, 25, f, p, s);
      chk("idle_no_pulse", 32'(f), 32'hFFFF_FFFF);

      for (int k = 0; k < 5; k++) begin
         hold(vals[k], 40, f, p, s);
         chk("walk_latency", 32'(f), 32'(LAT));
         chk("walk_num",     32'(p), 32'(idxs[k]));
         chk("walk_seq",     32'(s), 32'd0);
      end

      hold(4'b0010, 40, f, p, s);
      chk("pre_glitch_num", 32'(p), 32'd1);
      hold(4'b1000, 5, f, p, s);
      chk("glitch_pulse", 32'(f), 32'hFFFF_FFFF);
      hold(4'b0010, 40, f, p, s);
      chk("post_glitch_pulse", 32'(f), 32'hFFFF_FFFF);
      chk("post_glitch_num",   32'(bus.NUM), 32'd1);

      hold(4'b0110, 40, f, p, s);
      chk("multihot_pulse", 32'(f), 32'hFFFF_FFFF);
      chk("multihot_err",   32'(bus.ERR), 32'd1);
      chk("multihot_num",   32'(bus.NUM), 32'd1);
      hold(4'b0100, 40, f, p, s);
      chk("recover_latency", 32'(f), 32'(LAT));
      chk("recover_num",     32'(p), 32'd2);
      chk("recover_err",     32'(bus.ERR), 32'd0);

      hold(4'b0001, 40, f, p, s);
      hold(4'b0100, 40, f, p, s);
      chk("seq_jump_num", 32'(p), 32'd2);
      chk("seq_jump_err", 32'(s), 32'(SEQ_ON));
      hold(4'b0000, 40, f, p, s);
      chk("to_idle_idle", 32'(bus.IDLE), 32'd1);
      hold(4'b1000, 40, f, p, s);
      chk("after_idle_num", 32'(p), 32'd3);
      chk("after_idle_seq", 32'(s), 32'd0);

      hold(4'b0100, 10, f, p, s);
      chk("mid_debounce_pulse", 32'(f), 32'hFFFF_FFFF);
      step(4'b0100, 1'b1);
      step(4'b0100, 1'b1);
      chk("mid_rst_num",  32'(bus.NUM),  32'd0);
      chk("mid_rst_idle", 32'(bus.IDLE), 32'd1);
      hold(4'b0100, 40, f, p, s);
      chk("after_rst_latency", 32'(f), 32'(LAT));
      chk("after_rst_num",     32'(p), 32'd2);

      for (int r = 0; r < 300; r++) begin
         if ($urandom_range(0, 1) == 0) v = 4'(1 << $urandom_range(0, 3));
         else v = 4'($urandom_range(0, 15));
         n = $urandom_range(1, 30);
         if ($urandom_range(0, 39) == 0) step(v, 1'b1);
         hold(v, n, f, p, s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
